// File: rtl/motion_stream_driver.sv
// motion_stream_driver
//   Streaming front end for the combinational motion-corrector datapath.
//   Accepts Q16.16 points over valid/ready, registers them onto the mc_*
//   drive bus one per cycle, closes the velocity loop (v_next of one point
//   becomes v_prev of the next, cleared at frame start) and captures the
//   corrected point into an output FIFO drained over valid/ready.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   s_valid/s_ready           input point handshake
//   s_sof                     beat starts a frame (velocity cleared)
//   s_px/py/pz/dt/ax          input point, time step, acceleration (Q16.16)
//   mc_px/py/pz/dt/a_x/v_prev registered drive to the corrector
//   mc_v_next/cx/cy/cz        combinational corrector results
//   m_valid/m_ready           corrected point handshake
//   m_cx/cy/cz, m_sof         FIFO head (zero while empty)
//   point_cnt                 points accepted since last sof/reset
module motion_stream_driver #(
    parameter int WP         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [WP-1:0]    s_px,
    input  logic [WP-1:0]    s_py,
    input  logic [WP-1:0]    s_pz,
    input  logic [WP-1:0]    s_dt,
    input  logic [WP-1:0]    s_ax,
    output logic [WP-1:0]    mc_px,
    output logic [WP-1:0]    mc_py,
    output logic [WP-1:0]    mc_pz,
    output logic [WP-1:0]    mc_dt,
    output logic [WP-1:0]    mc_a_x,
    output logic [WP-1:0]    mc_v_prev,
    input  logic [WP-1:0]    mc_v_next,
    input  logic [WP-1:0]    mc_cx,
    input  logic [WP-1:0]    mc_cy,
    input  logic [WP-1:0]    mc_cz,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WP-1:0]    m_cx,
    output logic [WP-1:0]    m_cy,
    output logic [WP-1:0]    m_cz,
    output logic             m_sof,
    output logic [CNT_W-1:0] point_cnt
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = AW + 1;   // FIFO count, 0..FIFO_DEPTH
    localparam int OW = AW + 2;   // count + in-flight point, no wrap
    localparam int EW = 3 * WP + 1;

    logic [WP-1:0]    mc_px_q, mc_px_d, mc_py_q, mc_py_d, mc_pz_q, mc_pz_d;
    logic [WP-1:0]    mc_dt_q, mc_dt_d, mc_a_x_q, mc_a_x_d;
    logic [WP-1:0]    mc_v_prev_q, mc_v_prev_d, v_q, v_d;
    logic             s1_v_q, s1_v_d, s1_sof_q, s1_sof_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] point_cnt_q, point_cnt_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];

    logic          accept, push, pop;
    logic [OW-1:0] occ;
    logic [EW-1:0] head;

    // Occupancy counts the point still in the corrector so a push can never
    // land on a full FIFO; it uses the registered count, so a pop on a full
    // FIFO does not open s_ready in the same cycle.
    assign occ     = OW'(cnt_q) + OW'(s1_v_q);
    assign s_ready = !rst && (occ < OW'(FIFO_DEPTH));
    assign accept  = s_valid && s_ready;
    assign push    = s1_v_q;
    assign pop     = m_valid && m_ready;

    always_comb begin
        mc_px_d     = mc_px_q;
        mc_py_d     = mc_py_q;
        mc_pz_d     = mc_pz_q;
        mc_dt_d     = mc_dt_q;
        mc_a_x_d    = mc_a_x_q;
        mc_v_prev_d = mc_v_prev_q;
        s1_sof_d    = s1_sof_q;
        s1_v_d      = accept;
        v_d         = v_q;
        point_cnt_d = point_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        mem_d       = mem_q;

        if (accept) begin
            mc_px_d  = s_px;
            mc_py_d  = s_py;
            mc_pz_d  = s_pz;
            mc_dt_d  = s_dt;
            mc_a_x_d = s_ax;
            s1_sof_d = s_sof;
            // Back-to-back points take v_next straight from the corrector,
            // since held v only updates on this same edge.
            if (s_sof)       mc_v_prev_d = '0;
            else if (s1_v_q) mc_v_prev_d = mc_v_next;
            else             mc_v_prev_d = v_q;
            point_cnt_d = s_sof ? CNT_W'(1) : point_cnt_q + CNT_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = {mc_cx, mc_cy, mc_cz, s1_sof_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            v_d             = mc_v_next;
        end

        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + NW'(1);
            2'b01:   cnt_d = cnt_q - NW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_px_q     <= '0;
            mc_py_q     <= '0;
            mc_pz_q     <= '0;
            mc_dt_q     <= '0;
            mc_a_x_q    <= '0;
            mc_v_prev_q <= '0;
            v_q         <= '0;
            s1_v_q      <= 1'b0;
            s1_sof_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            point_cnt_q <= '0;
        end else begin
            mc_px_q     <= mc_px_d;
            mc_py_q     <= mc_py_d;
            mc_pz_q     <= mc_pz_d;
            mc_dt_q     <= mc_dt_d;
            mc_a_x_q    <= mc_a_x_d;
            mc_v_prev_q <= mc_v_prev_d;
            v_q         <= v_d;
            s1_v_q      <= s1_v_d;
            s1_sof_q    <= s1_sof_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            point_cnt_q <= point_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign mc_px     = mc_px_q;
    assign mc_py     = mc_py_q;
    assign mc_pz     = mc_pz_q;
    assign mc_dt     = mc_dt_q;
    assign mc_a_x    = mc_a_x_q;
    assign mc_v_prev = mc_v_prev_q;
    assign point_cnt = point_cnt_q;

    assign m_valid = (cnt_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign m_cx    = m_valid ? head[EW-1 -: WP]     : '0;
    assign m_cy    = m_valid ? head[EW-1-WP -: WP]  : '0;
    assign m_cz    = m_valid ? head[EW-1-2*WP -: WP] : '0;
    assign m_sof   = m_valid && head[0];
endmodule

// File: tb/tb_motion_stream_driver.sv
// Directed and random bench for motion_stream_driver, with a stub corrector:
//   v_next = v_prev + (a_x*dt)>>>16, cx = px - (v_prev*dt)>>>16, cy = py, cz = pz.
module tb_motion_stream_driver;
    localparam int WP = 32;
    localparam int FD = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, s_valid, s_ready, s_sof, m_valid, m_ready, m_sof;
    logic [WP-1:0] s_px, s_py, s_pz, s_dt, s_ax;
    logic [WP-1:0] mc_px, mc_py, mc_pz, mc_dt, mc_a_x, mc_v_prev;
    logic [WP-1:0] mc_v_next, mc_cx, mc_cy, mc_cz;
    logic [WP-1:0] m_cx, m_cy, m_cz;
    logic [CW-1:0] point_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    motion_stream_driver #(.WP(WP), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_px(s_px), .s_py(s_py), .s_pz(s_pz), .s_dt(s_dt), .s_ax(s_ax),
        .mc_px(mc_px), .mc_py(mc_py), .mc_pz(mc_pz), .mc_dt(mc_dt), .mc_a_x(mc_a_x),
        .mc_v_prev(mc_v_prev), .mc_v_next(mc_v_next), .mc_cx(mc_cx), .mc_cy(mc_cy),
        .mc_cz(mc_cz), .m_valid(m_valid), .m_ready(m_ready), .m_cx(m_cx), .m_cy(m_cy),
        .m_cz(m_cz), .m_sof(m_sof), .point_cnt(point_cnt)
    );

    // Q16.16 product, truncated back to a 32-bit word.
    function automatic logic [31:0] mulq(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[47:16];
    endfunction

    always_comb begin
        mc_v_next = mc_v_prev + mulq(mc_a_x, mc_dt);
        mc_cx     = mc_px - mulq(mc_v_prev, mc_dt);
        mc_cy     = mc_py;
        mc_cz     = mc_pz;
    end

    task automatic set_beat(input logic v, input logic sof, input logic [31:0] px,
                            input logic [31:0] py, input logic [31:0] dt, input logic [31:0] ax);
        s_valid = v; s_sof = sof; s_px = px; s_py = py; s_pz = px ^ py; s_dt = dt; s_ax = ax;
    endtask

    // Leaves the caller just after a negedge with rst released.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; m_ready = 1'b0;
        set_beat(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        total_cnt++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else pass_cnt++;
        total_cnt++; if (point_cnt !== 4'd0) $display("FAIL rst_point_cnt: got %0d want 0", point_cnt); else pass_cnt++;
        total_cnt++; if ({mc_px, mc_v_prev, m_cx, m_sof} !== '0) $display("FAIL rst_zero_outs: got %h want 0", {mc_px, mc_v_prev, m_cx, m_sof}); else pass_cnt++;
        s_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic test_basic();
        reset_dut();
        m_ready = 1'b1;
        set_beat(1'b1, 1'b1, 32'h20000, 32'h11, 32'h10000, 32'h18000);
        #1;
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL basic_s_ready: got %b want 1", s_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL basic_latency: m_valid got %b want 0", m_valid); else pass_cnt++;
        total_cnt++; if (mc_v_prev !== 32'h0) $display("FAIL basic_vprev0: got %h want 0", mc_v_prev); else pass_cnt++;
        set_beat(1'b1, 1'b0, 32'h20000, 32'h33, 32'h10000, 32'h18000);
        @(negedge clk);
        s_valid = 1'b0;
        total_cnt++; if (mc_v_prev !== 32'h18000) $display("FAIL basic_vprev1: got %h want 18000", mc_v_prev); else pass_cnt++;
        total_cnt++; if ({m_valid, m_cx, m_cy, m_sof} !== {1'b1, 32'h20000, 32'h11, 1'b1})
            $display("FAIL basic_beat0: got v=%b cx=%h cy=%h sof=%b want v=1 cx=20000 cy=11 sof=1", m_valid, m_cx, m_cy, m_sof); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({m_valid, m_cx, m_cy, m_sof} !== {1'b1, 32'h8000, 32'h33, 1'b0})
            $display("FAIL basic_beat1: got v=%b cx=%h cy=%h sof=%b want v=1 cx=8000 cy=33 sof=0", m_valid, m_cx, m_cy, m_sof); else pass_cnt++;
        total_cnt++; if (point_cnt !== 4'd2) $display("FAIL basic_point_cnt: got %0d want 2", point_cnt); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL basic_drained: m_valid got %b want 0", m_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        reset_dut();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            set_beat(1'b1, n == 0, 32'((n + 1) << 12), 32'(n + 'h100), 32'h10000, 32'h0);
            #1;
            if (s_ready) n++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        total_cnt++; if (n != 4) $display("FAIL bp_accepts: got %0d want 4", n); else pass_cnt++;
        total_cnt++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_full: got %b want 0", s_ready); else pass_cnt++;
        m_ready = 1'b1;
        #1;
        total_cnt++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_pop_full: got %b want 0", s_ready); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if ({m_valid, m_cx, m_cy, m_sof} !== {1'b1, 32'((k + 1) << 12), 32'(k + 'h100), k == 0})
                $display("FAIL bp_drain%0d: got v=%b cx=%h cy=%h sof=%b want cx=%h", k, m_valid, m_cx, m_cy, m_sof, 32'((k + 1) << 12));
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL bp_no_dup: m_valid got %b want 0", m_valid); else pass_cnt++;
    endtask

    task automatic test_sof_mid();
        reset_dut();
        m_ready = 1'b1;
        set_beat(1'b1, 1'b1, 32'h50000, 32'h1, 32'h10000, 32'h10000);
        @(negedge clk);
        set_beat(1'b1, 1'b0, 32'h60000, 32'h2, 32'h10000, 32'h10000);
        @(negedge clk);
        total_cnt++; if (mc_v_prev !== 32'h10000) $display("FAIL sof_vprev_b2: got %h want 10000", mc_v_prev); else pass_cnt++;
        set_beat(1'b1, 1'b1, 32'h70000, 32'h3, 32'h10000, 32'h10000);
        @(negedge clk);
        s_valid = 1'b0;
        total_cnt++; if (mc_v_prev !== 32'h0) $display("FAIL sof_vprev_b3: got %h want 0", mc_v_prev); else pass_cnt++;
        total_cnt++; if (point_cnt !== 4'd1) $display("FAIL sof_point_cnt: got %0d want 1", point_cnt); else pass_cnt++;
        total_cnt++; if (m_cx !== 32'h50000) $display("FAIL sof_cx_b2: got %h want 50000", m_cx); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({m_valid, m_cx, m_sof} !== {1'b1, 32'h70000, 1'b1})
            $display("FAIL sof_cx_b3: got v=%b cx=%h sof=%b want v=1 cx=70000 sof=1", m_valid, m_cx, m_sof); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(1'b1, i == 0, 32'h10000, 32'(i), 32'h10000, 32'h10000);
            @(negedge clk);
        end
        s_valid = 1'b0; rst = 1'b1;
        #1;
        total_cnt++; if (s_ready !== 1'b0) $display("FAIL rmid_s_ready: got %b want 0", s_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; m_ready = 1'b1;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid: got %b want 0", m_valid); else pass_cnt++;
        total_cnt++; if (point_cnt !== 4'd0) $display("FAIL rmid_point_cnt: got %0d want 0", point_cnt); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rmid_inflight: m_valid got %b want 0", m_valid); else pass_cnt++;
        set_beat(1'b1, 1'b0, 32'h30000, 32'h9, 32'h10000, 32'h10000);
        @(negedge clk);
        s_valid = 1'b0;
        total_cnt++; if (mc_v_prev !== 32'h0) $display("FAIL rmid_vprev: got %h want 0", mc_v_prev); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({m_valid, m_cx} !== {1'b1, 32'h30000}) $display("FAIL rmid_cx: got v=%b cx=%h want v=1 cx=30000", m_valid, m_cx); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        reset_dut();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_beat(1'b1, 1'b0, 32'(i), 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (i == 15) begin
                total_cnt++; if (point_cnt !== 4'd0) $display("FAIL wrap_16: got %0d want 0", point_cnt); else pass_cnt++;
            end
        end
        s_valid = 1'b0;
        total_cnt++; if (point_cnt !== 4'd1) $display("FAIL wrap_17: got %0d want 1", point_cnt); else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [3*WP:0] exp_q[$];
        logic [3*WP:0] prev_m, got;
        logic [31:0]   mv;
        logic          prev_stall;
        int acc, cyc, bad_stab;
        reset_dut();
        mv = '0; acc = 0; cyc = 0; prev_stall = 1'b0; prev_m = '0; bad_stab = 0;
        while ((acc < 1000 || exp_q.size() != 0) && cyc < 30000) begin
            got = {m_cx, m_cy, m_cz, m_sof};
            if (prev_stall && (!m_valid || got !== prev_m)) begin
                bad_stab++;
                $display("FAIL rand_stable: got v=%b %h want held %h", m_valid, got, prev_m);
            end
            m_ready = $urandom_range(0, 3) != 0;
            if (acc < 1000)
                set_beat($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom, $urandom,
                         $urandom_range(0, 32'h20000), $urandom_range(0, 32'h40000) - 32'h20000);
            else
                s_valid = 1'b0;
            #1;
            if (s_valid && s_ready) begin
                if (s_sof) mv = '0;
                exp_q.push_back({s_px - mulq(mv, s_dt), s_py, s_pz, s_sof});
                mv = mv + mulq(s_ax, s_dt);
                acc++;
            end
            if (m_valid && m_ready) begin
                total_cnt++;
                if (exp_q.size() == 0 || got !== exp_q[0])
                    $display("FAIL rand_beat: got %h want %h", got, (exp_q.size() != 0) ? exp_q[0] : '0);
                else pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_stall = m_valid && !m_ready;
            prev_m = got;
            @(negedge clk);
            cyc++;
        end
        total_cnt++; if (bad_stab != 0) $display("FAIL rand_stable_total: got %0d unstable cycles want 0", bad_stab); else pass_cnt++;
        total_cnt++; if (acc < 1000 || exp_q.size() != 0)
            $display("FAIL rand_timeout: accepted %0d pending %0d want 1000 and 0", acc, exp_q.size()); else pass_cnt++;
        m_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rand_extra: m_valid got %b want 0", m_valid); else pass_cnt++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; m_ready = 1'b0;
        set_beat(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_basic();
        test_backpressure();
        test_sof_mid();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/motion_stream_driver.md
Name: motion_stream_driver

Overview:
Sequential streaming front end that drives the team's combinational motion-corrector datapath (mc_* port group) and closes its velocity loop. Accepts Q16.16 points over valid/ready and presents them to the corrector one per cycle. Feeds the corrector's v_next back as v_prev for the next point, clearing velocity at frame start. Captures corrected points into an output FIFO drained over valid/ready.

Parameters:
WP, 32, data width of all Q16.16 signed words
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 16, width of point counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input point valid
s_ready  out  1  input point ready
s_sof  in  1  beat is first point of a frame (velocity cleared)
s_px, s_py, s_pz  in  WP each  point coordinates, Q16.16
s_dt  in  WP  time step, Q16.16
s_ax  in  WP  acceleration for this beat, Q16.16
mc_px, mc_py, mc_pz, mc_dt, mc_a_x, mc_v_prev  out  WP each  registered drive to corrector
mc_v_next, mc_cx, mc_cy, mc_cz  in  WP each  combinational corrector results
m_valid  out  1  corrected point valid
m_ready  in  1  downstream ready
m_cx, m_cy, m_cz  out  WP each  corrected point, Q16.16
m_sof  out  1  corrected point is frame start
point_cnt  out  CNT_W  points accepted since last sof/reset

Behaviour:
- Reset (sync, rst=1 at edge): all mc_* = 0, internal v = 0, stage-valid s1_v = 0, FIFO empty, m_valid = 0, m_c* = 0, m_sof = 0, point_cnt = 0. s_ready = 0 while rst high; may assert the cycle after.
- Reset mid-operation discards the in-flight point and all FIFO contents; no partial output beats.
- Stage 1 (drive): on s_valid && s_ready, register s_px/py/pz/dt/ax into mc_* and set s1_v = 1, s1_sof = s_sof. mc_v_prev <= 0 if s_sof, else mc_v_next of the previously driven point when s1_v = 1, else held v. Without an accept, mc_* hold and s1_v <= 0.
- Stage 2 (capture): on the edge after drive (s1_v=1), push {mc_cx, mc_cy, mc_cz, s1_sof} into the FIFO and update held v <= mc_v_next. The same edge may accept the next point; its mc_v_prev is that mc_v_next (zero if sof).
- Latency: accept edge N -> FIFO write edge N+1 -> m_valid high after edge N+1 if the FIFO was empty. Throughput 1 point/cycle.
- s_ready = (fifo_count + s1_v) < FIFO_DEPTH. No FIFO overflow possible.
- Output: m_valid = FIFO non-empty; m_* = head entry; pop on m_valid && m_ready. m_* stable while m_valid && !m_ready. Simultaneous push and pop keep the count unchanged. Full FIFO with pop on the same cycle: s_ready stays low that cycle (registered count).
- point_cnt: on accept, = 1 if s_sof else point_cnt+1; wraps at 2^CNT_W to 0.
- Arithmetic: none inside the block. Values pass unmodified, with no saturation or rounding. Velocity overflow is the corrector's responsibility.
- sof with s_valid low is ignored.

Test Plan:
Bench stub corrector: v_next = v_prev + (a_x*dt)>>>16; cx = px - (v_prev*dt)>>>16; cy = py; cz = pz.
1. After reset, two beats px=0x20000, dt=0x10000, ax=0x18000, first with sof=1, m_ready=1 -> m_cx=0x20000 (m_sof=1), then 0x8000; point_cnt=2; m_valid first high 2 cycles after first accept.
2. 4-beat burst with m_ready=0 -> s_ready drops after 4 accepts (FIFO_DEPTH=4); release m_ready -> 4 beats in order, no loss or duplication.
3. sof=1 on the 3rd beat of a stream -> its mc_v_prev=0, m_cx=px, point_cnt=1.
4. rst pulsed one cycle with 2 points in FIFO and 1 in flight -> m_valid=0 next cycle, point_cnt=0, next beat sees mc_v_prev=0.
5. Random s_valid/m_ready toggling, 1000 beats -> output matches the stub model sequence; m_* stable under backpressure.
6. 2^CNT_W+1 beats without sof (CNT_W=4: 17 beats) -> point_cnt wraps to 1.
